uart_pi_v2: RTL and testbench

Second-generation UART processor-interface register block. It sits between the uP bus and the UART TX/RX FIFOs and the baud-rate generator. Compared with the first generation it adds:
- a parametrised baud divisor, wider than 8 bits, updated atomically;
- a maskable, per-source, write-1-to-clear interrupt status register;
- sticky overrun and TX-drop flags;
- registered read data with a valid strobe.

---
 rtl/uart_pi_v2_if.sv | 21 ++
 rtl/uart_pi_v2.sv | 147 ++++++++++++++
 tb/tb_uart_pi_v2.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pi_v2_if.sv
// Processor-interface bus of the UART register block: host access strobes
// plus the registered read-return path.
interface uart_pi_if;
  logic       pi_blk_sel;
  logic [3:0] pi_addr;
  logic       pi_wr_en;
  logic       pi_rd_en;
  logic [7:0] pi_wr_data;
  logic [7:0] pi_rd_data;
  logic       pi_rd_valid;

  modport master (
    output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    input  pi_rd_data, pi_rd_valid
  );

  modport slave (
    input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    output pi_rd_data, pi_rd_valid
  );
endinterface

// File: rtl/uart_pi_v2.sv
// UART processor-interface register block: FIFO access, atomic baud divisor,
// maskable W1C interrupt status and sticky error flags.
module uart_pi_v2 #(
  parameter int unsigned CLK_MHZ   = 75,
  parameter int unsigned BAUD_RATE = 128000,
  parameter int unsigned DIV_W     = 16,
`ifdef SIM
  parameter int unsigned DEF_DIV   = 2
`else
  parameter int unsigned DEF_DIV   = (CLK_MHZ * 62500 / BAUD_RATE) - 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  uart_pi_if.slave         pi,
  input  logic             interrupt_ack,
  output logic             interrupt,
  input  logic             tx_fifo_overrun,
  input  logic             tx_fifo_rdy,
  output logic             tx_fifo_wr_en,
  output logic [7:0]       tx_fifo_wr_data,
  input  logic             rx_fifo_overrun,
  input  logic             rx_fifo_rdy,
  output logic             rx_fifo_rd_en,
  input  logic [7:0]       rx_fifo_rd_data,
  output logic [DIV_W-1:0] baud_16x_in_cycles
);

  localparam logic [3:0] ADDR_STATUS     = 4'h0;
  localparam logic [3:0] ADDR_READ_FIFO  = 4'h1;
  localparam logic [3:0] ADDR_WRITE_FIFO = 4'h2;
  localparam logic [3:0] ADDR_DIV_LO     = 4'h3;
  localparam logic [3:0] ADDR_DIV_HI     = 4'h4;
  localparam logic [3:0] ADDR_IRQ_EN     = 4'h5;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'h6;
  localparam logic [3:0] ADDR_STICKY_CLR = 4'h7;

  logic             wr_acc_s, rd_acc_s, drop_s;
  logic [2:0]       evt_in_s, evt_q_r, evt_qq_r, evt_edge_s;
  logic [3:0]       irq_en_r, irq_en_nxt_s;
  logic [3:0]       irq_status_r, irq_status_nxt_s;
  logic [3:0]       irq_set_s, irq_w1c_s, irq_clr_s;
  logic [2:0]       stk_clr_s;
  logic             rx_ovr_stk_r, tx_ovr_stk_r, tx_drop_stk_r;
  logic             rx_ovr_stk_nxt_s, tx_ovr_stk_nxt_s, tx_drop_stk_nxt_s;
  logic [7:0]       shadow_r, shadow_nxt_s;
  logic [DIV_W-1:0] div_nxt_s;
  logic [15:0]      div_ext_s;
  logic [7:0]       rd_mux_s;

  // Access decode and the same-cycle FIFO strobes
  always_comb begin
    wr_acc_s        = pi.pi_blk_sel & pi.pi_wr_en;
    rd_acc_s        = pi.pi_blk_sel & pi.pi_rd_en;
    tx_fifo_wr_en   = wr_acc_s & (pi.pi_addr == ADDR_WRITE_FIFO) & tx_fifo_rdy;
    drop_s          = wr_acc_s & (pi.pi_addr == ADDR_WRITE_FIFO) & ~tx_fifo_rdy;
    tx_fifo_wr_data = pi.pi_wr_data;
    rx_fifo_rd_en   = rd_acc_s & (pi.pi_addr == ADDR_READ_FIFO) & rx_fifo_rdy;
  end

  // Register-file next state; event sets always win over any clear source
  always_comb begin
    evt_in_s     = {tx_fifo_rdy, rx_fifo_overrun, rx_fifo_rdy};
    evt_edge_s   = evt_q_r & ~evt_qq_r;
    irq_set_s    = {drop_s, evt_edge_s};
    irq_w1c_s    = 4'h0;
    irq_en_nxt_s = irq_en_r;
    stk_clr_s    = 3'b000;
    shadow_nxt_s = shadow_r;
    div_nxt_s    = baud_16x_in_cycles;
    if (wr_acc_s) begin
      case (pi.pi_addr)
        ADDR_DIV_LO:     shadow_nxt_s = pi.pi_wr_data;
        ADDR_DIV_HI:     div_nxt_s    = {pi.pi_wr_data[DIV_W-9:0], shadow_r};
        ADDR_IRQ_EN:     irq_en_nxt_s = pi.pi_wr_data[3:0];
        ADDR_IRQ_STATUS: irq_w1c_s    = pi.pi_wr_data[3:0];
        ADDR_STICKY_CLR: stk_clr_s    = pi.pi_wr_data[2:0];
        default:         shadow_nxt_s = shadow_r;
      endcase
    end else begin
      shadow_nxt_s = shadow_r;
    end
    if (interrupt_ack) begin
      irq_clr_s = 4'hF;
    end else begin
      irq_clr_s = irq_w1c_s;
    end
    irq_status_nxt_s  = (irq_status_r & ~irq_clr_s) | irq_set_s;
    rx_ovr_stk_nxt_s  = rx_fifo_overrun | (rx_ovr_stk_r & ~stk_clr_s[0]);
    tx_ovr_stk_nxt_s  = tx_fifo_overrun | (tx_ovr_stk_r & ~stk_clr_s[1]);
    tx_drop_stk_nxt_s = drop_s | (tx_drop_stk_r & ~stk_clr_s[2]);
  end

  // Read mux, sampled in the access cycle before any pop takes effect
  always_comb begin
    div_ext_s = 16'(baud_16x_in_cycles);
    rd_mux_s  = 8'h00;
    case (pi.pi_addr)
      ADDR_STATUS:     rd_mux_s = {2'b00, tx_drop_stk_r, tx_ovr_stk_r, rx_ovr_stk_r,
                                   tx_fifo_rdy, rx_fifo_rdy, 1'b0};
      ADDR_READ_FIFO: begin
        if (rx_fifo_rdy) begin
          rd_mux_s = rx_fifo_rd_data;
        end else begin
          rd_mux_s = 8'h00;
        end
      end
      ADDR_DIV_LO:     rd_mux_s = div_ext_s[7:0];
      ADDR_DIV_HI:     rd_mux_s = div_ext_s[15:8];
      ADDR_IRQ_EN:     rd_mux_s = {4'h0, irq_en_r};
      ADDR_IRQ_STATUS: rd_mux_s = {4'h0, irq_status_r};
      default:         rd_mux_s = 8'h00;
    endcase
  end

  // State registers; interrupt tracks the next-cycle status so it has no extra lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q_r            <= 3'b000;
      evt_qq_r           <= 3'b000;
      irq_en_r           <= 4'h0;
      irq_status_r       <= 4'h0;
      rx_ovr_stk_r       <= 1'b0;
      tx_ovr_stk_r       <= 1'b0;
      tx_drop_stk_r      <= 1'b0;
      shadow_r           <= 8'h00;
      baud_16x_in_cycles <= DIV_W'(DEF_DIV);
      interrupt          <= 1'b0;
      pi.pi_rd_data      <= 8'h00;
      pi.pi_rd_valid     <= 1'b0;
    end else begin
      evt_q_r            <= evt_in_s;
      evt_qq_r           <= evt_q_r;
      irq_en_r           <= irq_en_nxt_s;
      irq_status_r       <= irq_status_nxt_s;
      rx_ovr_stk_r       <= rx_ovr_stk_nxt_s;
      tx_ovr_stk_r       <= tx_ovr_stk_nxt_s;
      tx_drop_stk_r      <= tx_drop_stk_nxt_s;
      shadow_r           <= shadow_nxt_s;
      baud_16x_in_cycles <= div_nxt_s;
      interrupt          <= |(irq_status_nxt_s & irq_en_nxt_s);
      pi.pi_rd_data      <= rd_acc_s ? rd_mux_s : 8'h00;
      pi.pi_rd_valid     <= rd_acc_s;
    end
  end

endmodule

// File: tb/tb_uart_pi_v2.sv
// Self-checking bench for uart_pi_v2: register table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_uart_pi_v2;
  localparam int DIV_W = 16;
`ifdef SIM
  localparam int EXP_DEF_DIV = 2;
`else
  localparam int EXP_DEF_DIV = (75 * 62500 / 128000) - 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             interrupt_ack, interrupt;
  logic             tx_fifo_overrun, tx_fifo_rdy, tx_fifo_wr_en;
  logic [7:0]       tx_fifo_wr_data;
  logic             rx_fifo_overrun, rx_fifo_rdy, rx_fifo_rd_en;
  logic [7:0]       rx_fifo_rd_data;
  logic [DIV_W-1:0] baud_16x_in_cycles;

  uart_pi_if pi_bus ();

  uart_pi_v2 #(.CLK_MHZ(75), .BAUD_RATE(128000), .DIV_W(DIV_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .pi                 (pi_bus),
    .interrupt_ack      (interrupt_ack),
    .interrupt          (interrupt),
    .tx_fifo_overrun    (tx_fifo_overrun),
    .tx_fifo_rdy        (tx_fifo_rdy),
    .tx_fifo_wr_en      (tx_fifo_wr_en),
    .tx_fifo_wr_data    (tx_fifo_wr_data),
    .rx_fifo_overrun    (rx_fifo_overrun),
    .rx_fifo_rdy        (rx_fifo_rdy),
    .rx_fifo_rd_en      (rx_fifo_rd_en),
    .rx_fifo_rd_data    (rx_fifo_rd_data),
    .baud_16x_in_cycles (baud_16x_in_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  always @(posedge clk) begin
    if (rx_fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (tx_fifo_wr_en) wr_pulses <= wr_pulses + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pi_bus.pi_blk_sel = 1'b0;
    pi_bus.pi_wr_en   = 1'b0;
    pi_bus.pi_rd_en   = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_wr_en   = 1'b1;
    pi_bus.pi_rd_en   = 1'b0;
    pi_bus.pi_addr    = a;
    pi_bus.pi_wr_data = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_rd_en   = 1'b1;
    pi_bus.pi_wr_en   = 1'b0;
    pi_bus.pi_addr    = a;
    cyc();
    idle();
    chk("rd_valid", 32'(pi_bus.pi_rd_valid), 32'd1);
    d = pi_bus.pi_rd_data;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    logic [15:0] exp_baud;
  } vec_t;

  vec_t tbl [16];

  // Behavioural model state for the randomized run
  logic [3:0]  m_en, m_st;
  logic [2:0]  m_stk;
  logic [7:0]  m_sh;
  logic [15:0] m_div;
  logic [2:0]  h1, h2;

  initial begin
    logic [7:0]  d;
    logic [15:0] dd;
    int          p;

    dd = 16'(EXP_DEF_DIV);
    tbl[0]  = '{1'b1, 4'h5, 8'h0B, 8'h00, dd};
    tbl[1]  = '{1'b0, 4'h5, 8'h00, 8'h0B, dd};
    tbl[2]  = '{1'b1, 4'h3, 8'h34, 8'h00, dd};
    tbl[3]  = '{1'b0, 4'h3, 8'h00, dd[7:0], dd};
    tbl[4]  = '{1'b1, 4'h4, 8'h12, 8'h00, 16'h1234};
    tbl[5]  = '{1'b0, 4'h3, 8'h00, 8'h34, 16'h1234};
    tbl[6]  = '{1'b0, 4'h4, 8'h00, 8'h12, 16'h1234};
    tbl[7]  = '{1'b1, 4'h9, 8'hFF, 8'h00, 16'h1234};
    tbl[8]  = '{1'b0, 4'h9, 8'h00, 8'h00, 16'h1234};
    tbl[9]  = '{1'b0, 4'h2, 8'h00, 8'h00, 16'h1234};
    tbl[10] = '{1'b0, 4'h7, 8'h00, 8'h00, 16'h1234};
    tbl[11] = '{1'b1, 4'h3, 8'h56, 8'h00, 16'h1234};
    tbl[12] = '{1'b0, 4'h3, 8'h00, 8'h34, 16'h1234};
    tbl[13] = '{1'b1, 4'h4, 8'h00, 8'h00, 16'h0056};
    tbl[14] = '{1'b0, 4'h4, 8'h00, 8'h00, 16'h0056};
    tbl[15] = '{1'b1, 4'h5, 8'h00, 8'h00, 16'h0056};

    // Reset with tx space already available
    rst = 1'b1;
    idle();
    pi_bus.pi_addr = 4'h0;
    pi_bus.pi_wr_data = 8'h00;
    interrupt_ack = 1'b0;
    tx_fifo_overrun = 1'b0;
    tx_fifo_rdy = 1'b1;
    rx_fifo_overrun = 1'b0;
    rx_fifo_rdy = 1'b0;
    rx_fifo_rd_data = 8'h00;
    repeat (3) cyc();
    chk("reset_baud", 32'(baud_16x_in_cycles), 32'(EXP_DEF_DIV));
    chk("reset_interrupt", 32'(interrupt), 32'd0);
    chk("reset_rd_valid", 32'(pi_bus.pi_rd_valid), 32'd0);
    chk("reset_rd_data", 32'(pi_bus.pi_rd_data), 32'd0);
    rst = 1'b0;
    rd(4'h0, d);
    chk("status_after_reset", 32'(d), 32'h04);
    cyc(); cyc();
    rd(4'h6, d);
    chk("irq_tx_rdy_at_release", 32'(d), 32'h04);
    wr(4'h6, 8'h0F);
    rd(4'h6, d);
    chk("irq_w1c_all", 32'(d), 32'h00);

    // Register table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
      end else begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl_rd[%0d]", i), 32'(d), 32'(tbl[i].exp_rd));
      end
      chk($sformatf("tbl_baud[%0d]", i), 32'(baud_16x_in_cycles), 32'(tbl[i].exp_baud));
    end

    // RX data-available interrupt, pop and W1C
    wr(4'h5, 8'h01);
    rx_fifo_rd_data = 8'hA5;
    rx_fifo_rdy = 1'b1;
    cyc();
    chk("rx_irq_n1", 32'(interrupt), 32'd0);
    cyc();
    chk("rx_irq_n2", 32'(interrupt), 32'd1);
    p = rd_pulses;
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_rd_en = 1'b1;
    pi_bus.pi_addr = 4'h1;
    #3;
    chk("rx_rd_en_pulse", 32'(rx_fifo_rd_en), 32'd1);
    cyc();
    idle();
    chk("rx_rd_valid", 32'(pi_bus.pi_rd_valid), 32'd1);
    chk("rx_rd_data", 32'(pi_bus.pi_rd_data), 32'hA5);
    chk("rx_pop_count", 32'(rd_pulses - p), 32'd1);
    #1;
    chk("rx_rd_en_drop", 32'(rx_fifo_rd_en), 32'd0);
    wr(4'h6, 8'h01);
    chk("rx_irq_cleared", 32'(interrupt), 32'd0);
    rx_fifo_rdy = 1'b0;

    // TX full: drop, sticky, clear, then a real push
    tx_fifo_rdy = 1'b0;
    cyc(); cyc();
    p = wr_pulses;
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_wr_en = 1'b1;
    pi_bus.pi_addr = 4'h2;
    pi_bus.pi_wr_data = 8'h55;
    #3;
    chk("tx_full_no_wr_en", 32'(tx_fifo_wr_en), 32'd0);
    cyc();
    idle();
    chk("tx_full_push_count", 32'(wr_pulses - p), 32'd0);
    rd(4'h0, d);
    chk("tx_drop_status", 32'(d), 32'h20);
    rd(4'h6, d);
    chk("tx_drop_irq", 32'(d), 32'h08);
    wr(4'h7, 8'h04);
    rd(4'h0, d);
    chk("tx_drop_cleared", 32'(d), 32'h00);
    tx_fifo_rdy = 1'b1;
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_wr_en = 1'b1;
    pi_bus.pi_addr = 4'h2;
    pi_bus.pi_wr_data = 8'h3C;
    #3;
    chk("tx_push_wr_en", 32'(tx_fifo_wr_en), 32'd1);
    chk("tx_push_data", 32'(tx_fifo_wr_data), 32'h3C);
    cyc();
    idle();
    chk("tx_push_count", 32'(wr_pulses - p), 32'd1);

    // Collisions: set beats W1C, set beats interrupt_ack
    cyc(); cyc(); cyc();
    wr(4'h6, 8'h0F);
    rd(4'h6, d);
    chk("collide_pre_clear", 32'(d), 32'h00);
    rx_fifo_rdy = 1'b1;
    cyc();
    wr(4'h6, 8'h01);
    rd(4'h6, d);
    chk("collide_w1c", 32'(d & 8'h01), 32'h01);
    rx_fifo_rdy = 1'b0;
    cyc(); cyc();
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
    rd(4'h6, d);
    chk("ack_clears", 32'(d), 32'h00);
    rx_fifo_rdy = 1'b1;
    cyc();
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
    rd(4'h6, d);
    chk("collide_ack", 32'(d), 32'h01);
    chk("collide_ack_irq", 32'(interrupt), 32'd1);

    // Empty read
    rx_fifo_rdy = 1'b0;
    rx_fifo_rd_data = 8'h77;
    cyc(); cyc();
    p = rd_pulses;
    pi_bus.pi_blk_sel = 1'b1;
    pi_bus.pi_rd_en = 1'b1;
    pi_bus.pi_addr = 4'h1;
    #3;
    chk("empty_rd_en", 32'(rx_fifo_rd_en), 32'd0);
    cyc();
    idle();
    chk("empty_rd_valid", 32'(pi_bus.pi_rd_valid), 32'd1);
    chk("empty_rd_data", 32'(pi_bus.pi_rd_data), 32'h00);
    chk("empty_pop_count", 32'(rd_pulses - p), 32'd0);
    cyc();
    chk("idle_rd_valid", 32'(pi_bus.pi_rd_valid), 32'd0);
    chk("idle_rd_data", 32'(pi_bus.pi_rd_data), 32'h00);

    // Randomized run against the behavioural model
    rst = 1'b1;
    tx_fifo_rdy = 1'b0;
    rx_fifo_rdy = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    m_en = 4'h0; m_st = 4'h0; m_stk = 3'b000; m_sh = 8'h00;
    m_div = 16'(EXP_DEF_DIV); h1 = 3'b000; h2 = 3'b000;
    for (int i = 0; i < 600; i++) begin
      logic       ra, wa, drop, erd_v;
      logic [7:0] erd;
      logic [3:0] set, clr;
      logic [2:0] sclr, cur;
      pi_bus.pi_blk_sel = ($urandom_range(0, 3) != 0);
      pi_bus.pi_wr_en = ($urandom_range(0, 2) == 0);
      pi_bus.pi_rd_en = ($urandom_range(0, 2) == 0);
      pi_bus.pi_addr = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                                     : 4'($urandom_range(0, 7));
      pi_bus.pi_wr_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) tx_fifo_rdy = ~tx_fifo_rdy;
      if ($urandom_range(0, 7) == 0) rx_fifo_rdy = ~rx_fifo_rdy;
      rx_fifo_overrun = ($urandom_range(0, 9) == 0);
      tx_fifo_overrun = ($urandom_range(0, 9) == 0);
      interrupt_ack = ($urandom_range(0, 19) == 0);
      rx_fifo_rd_data = 8'($urandom);
      #3;
      ra = pi_bus.pi_blk_sel & pi_bus.pi_rd_en;
      wa = pi_bus.pi_blk_sel & pi_bus.pi_wr_en;
      chk("rnd_rx_rd_en", 32'(rx_fifo_rd_en), 32'(ra && pi_bus.pi_addr == 4'h1 && rx_fifo_rdy));
      chk("rnd_tx_wr_en", 32'(tx_fifo_wr_en), 32'(wa && pi_bus.pi_addr == 4'h2 && tx_fifo_rdy));
      if (wa && pi_bus.pi_addr == 4'h2 && tx_fifo_rdy)
        chk("rnd_tx_wr_data", 32'(tx_fifo_wr_data), 32'(pi_bus.pi_wr_data));
      case (pi_bus.pi_addr)
        4'h0:    erd = {2'b00, m_stk[2], m_stk[1], m_stk[0], tx_fifo_rdy, rx_fifo_rdy, 1'b0};
        4'h1:    erd = rx_fifo_rdy ? rx_fifo_rd_data : 8'h00;
        4'h3:    erd = m_div[7:0];
        4'h4:    erd = m_div[15:8];
        4'h5:    erd = {4'h0, m_en};
        4'h6:    erd = {4'h0, m_st};
        default: erd = 8'h00;
      endcase
      erd_v = ra;
      drop = wa && pi_bus.pi_addr == 4'h2 && !tx_fifo_rdy;
      set = {drop, h1 & ~h2};
      clr = interrupt_ack ? 4'hF : ((wa && pi_bus.pi_addr == 4'h6) ? pi_bus.pi_wr_data[3:0] : 4'h0);
      m_st = (m_st & ~clr) | set;
      if (wa && pi_bus.pi_addr == 4'h5) m_en = pi_bus.pi_wr_data[3:0];
      if (wa && pi_bus.pi_addr == 4'h4) m_div = {pi_bus.pi_wr_data, m_sh};
      if (wa && pi_bus.pi_addr == 4'h3) m_sh = pi_bus.pi_wr_data;
      sclr = (wa && pi_bus.pi_addr == 4'h7) ? pi_bus.pi_wr_data[2:0] : 3'b000;
      m_stk[0] = rx_fifo_overrun | (m_stk[0] & ~sclr[0]);
      m_stk[1] = tx_fifo_overrun | (m_stk[1] & ~sclr[1]);
      m_stk[2] = drop | (m_stk[2] & ~sclr[2]);
      cur = {tx_fifo_rdy, rx_fifo_overrun, rx_fifo_rdy};
      cyc();
      chk("rnd_rd_valid", 32'(pi_bus.pi_rd_valid), 32'(erd_v));
      chk("rnd_rd_data", 32'(pi_bus.pi_rd_data), erd_v ? 32'(erd) : 32'd0);
      chk("rnd_interrupt", 32'(interrupt), 32'(|(m_st & m_en)));
      chk("rnd_baud", 32'(baud_16x_in_cycles), 32'(m_div));
      h2 = h1;
      h1 = cur;
    end
    idle();
    interrupt_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
